adc128s_fc: RTL and testbench

- Behavioural/synthesizable model of an 8-channel, 12-bit SPI A2D converter (ADC128S-style) used as the analog front end in the Segway bench.
- Serves four analog quantities (left/right load cells, steering pot, battery) as 12-bit inputs.
- Returns each quantity over a 16-bit SPI frame protocol.
- Sits between the Segway A2D SPI master and the stimulus.

---
 rtl/adc128s_pkg.sv | 26 ++
 rtl/spi_edge_sync.sv | 42 ++++
 rtl/adc128s_fc.sv | 161 ++++++++++++++++
 tb/tb_adc128s_fc.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/adc128s_pkg.sv
// ---------------------------------------------------------------------------
// adc128s_pkg
// Shared constants for the ADC128S-style SPI A2D converter model:
//   - channel addresses decoded from command bits [13:11]
//   - SPI frame length and the matching bit-counter width
//   - frame-handling state encoding
// ---------------------------------------------------------------------------
package adc128s_pkg;

    localparam logic [2:0] CH_LFT   = 3'd0;
    localparam logic [2:0] CH_RGHT  = 3'd4;
    localparam logic [2:0] CH_STEER = 3'd5;
    localparam logic [2:0] CH_BATT  = 3'd6;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    // Bit counter value meaning "a complete frame was clocked in".
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// ---------------------------------------------------------------------------
// spi_edge_sync
// Two-flop synchronizer for one asynchronous SPI line plus a third flop used
// to detect edges of the synchronized level.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   async_i in   raw asynchronous input
//   sync_o  out  synchronized level (second flop)
//   rise_o  out  one-clk pulse on a synchronized 0->1 transition
//   fall_o  out  one-clk pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module spi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    // [0] = first sync flop, [1] = second sync flop, [2] = edge-detect flop.
    // Resetting to 0 means SS_n held low across reset never produces a
    // falling edge, so a frame already on the bus is ignored until the
    // master starts a fresh one.
    logic [2:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign sync_o = sync_q[1];
    assign rise_o =  sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/adc128s_fc.sv
// ---------------------------------------------------------------------------
// adc128s_fc
// Synthesizable model of an 8-channel 12-bit SPI A2D converter. Each 16-bit
// frame carries a channel command on MOSI (bits [13:11]) and returns, MSB
// first on MISO, the value selected by the previous complete frame as
// {4'b0000, data[11:0]}. The very first frame after reset returns 0.
// Ports:
//   clk          in   system clock, all logic on rising edge
//   rst          in   synchronous active-high reset
//   SS_n         in   SPI slave select, active low (async to clk)
//   SCLK         in   SPI clock, mode 0 (async to clk)
//   MOSI         in   SPI data from master (async to clk)
//   MISO         out  SPI data to master, registered
//   ld_cell_lft  in   12-bit value for channel 0
//   ld_cell_rght in   12-bit value for channel 4
//   steerPot     in   12-bit value for channel 5
//   batt         in   12-bit value for channel 6
// ---------------------------------------------------------------------------
module adc128s_fc
    import adc128s_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] ld_cell_lft,
    input  logic [11:0] ld_cell_rght,
    input  logic [11:0] steerPot,
    input  logic [11:0] batt
);

    // ---------------- input synchronization / edge detection ---------------
    logic ss_sync_unused, ss_rise, ss_fall;
    logic sclk_sync_unused, sclk_rise, sclk_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync u_sync_ss (
        .clk    (clk),
        .rst    (rst),
        .async_i(SS_n),
        .sync_o (ss_sync_unused),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    spi_edge_sync u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .async_i(SCLK),
        .sync_o (sclk_sync_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // MOSI goes through the same depth as SCLK so the sampled bit lines up
    // with the detected SCLK rise.
    spi_edge_sync u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .async_i(MOSI),
        .sync_o (mosi_sync),
        .rise_o (mosi_rise_unused),
        .fall_o (mosi_fall_unused)
    );

    // ---------------- state ------------------------------------------------
    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic [FRAME_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]              chnl_q, chnl_d;
    logic [11:0]             result_q, result_d;
    logic                    miso_d;
    logic [11:0]             sel_value;
    logic                    rx_msb_unused;

    // Only command bits [13:11] matter; the top received bit shifts out.
    assign rx_msb_unused = rx_shift_q[FRAME_BITS-1];

    // Channel mux addressed by the command just received, sampled in the
    // same cycle the frame-ending SS_n rise is seen.
    always_comb begin
        sel_value = 12'h000;
        case (rx_shift_q[13:11])
            CH_LFT:   sel_value = ld_cell_lft;
            CH_RGHT:  sel_value = ld_cell_rght;
            CH_STEER: sel_value = steerPot;
            CH_BATT:  sel_value = batt;
            default:  sel_value = 12'h000;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        chnl_d     = chnl_q;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    tx_shift_d = {4'b0000, result_q};
                    bit_cnt_d  = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    // Only a complete frame updates the selection; a short
                    // frame leaves the previously latched data in place.
                    if (bit_cnt_q == CNT_FULL) begin
                        chnl_d   = rx_shift_q[13:11];
                        result_d = sel_value;
                    end
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_sync};
                    if (bit_cnt_q != CNT_FULL) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall && (bit_cnt_q != '0)) begin
                    // Skipping falls before the first rise keeps bit 15 on
                    // the line for the master's first sample.
                    tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        // MISO is registered from next-state values so it follows the
        // shifter in the same clock instead of one clock later.
        miso_d = (state_d == SHIFT) ? tx_shift_d[FRAME_BITS-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            chnl_q     <= 3'd0;
            result_q   <= 12'h000;
            MISO       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            chnl_q     <= chnl_d;
            result_q   <= result_d;
            MISO       <= miso_d;
        end
    end

endmodule

// File: tb/tb_adc128s_fc.sv
// ---------------------------------------------------------------------------
// tb_adc128s_fc
// Self-checking bench for adc128s_fc: a table of back-to-back frames with
// hand-computed responses, then directed sequences for input-capture timing,
// aborted frames and reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_adc128s_fc;

    localparam int PH = 8;  // clk cycles per SCLK phase / SS_n setup

    logic        clk = 1'b0;
    logic        rst;
    logic        ss_n, sclk, mosi, miso;
    logic [11:0] lft, rght, steer, batt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adc128s_fc dut (
        .clk         (clk),
        .rst         (rst),
        .SS_n        (ss_n),
        .SCLK        (sclk),
        .MOSI        (mosi),
        .MISO        (miso),
        .ld_cell_lft (lft),
        .ld_cell_rght(rght),
        .steerPot    (steer),
        .batt        (batt)
    );

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] exp_resp;
        logic [2:0]  exp_chnl;
    } vec_t;

    vec_t vecs[10];

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One SPI mode-0 frame of n_bits SCLK pulses. MISO is sampled just
    // before each rising SCLK. Optionally batt changes after the 4th bit.
    task automatic spi_frame(input logic [15:0] cmd, input int n_bits,
                             input bit batt_change, input logic [11:0] batt_new,
                             output logic [15:0] resp);
        resp = 16'h0000;
        ss_n = 1'b0;
        mosi = cmd[15];
        wait_clks(PH);
        for (int i = 0; i < n_bits; i++) begin
            mosi = cmd[15-i];
            wait_clks(PH);
            resp = {resp[14:0], miso};
            sclk = 1'b1;
            wait_clks(PH);
            sclk = 1'b0;
            if (batt_change && i == 3) batt = batt_new;
        end
        wait_clks(PH);
        ss_n = 1'b1;
        wait_clks(PH);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] resp;

        vecs[0] = '{16'h0000, 16'h0000, 3'd0};  // first frame after reset
        vecs[1] = '{16'h2000, 16'h0ABC, 3'd4};  // returns ch0 selection
        vecs[2] = '{16'h2800, 16'h0123, 3'd5};
        vecs[3] = '{16'h3000, 16'h0456, 3'd6};
        vecs[4] = '{16'h0000, 16'h0C90, 3'd0};
        vecs[5] = '{16'h1800, 16'h0ABC, 3'd3};  // unused channel 3
        vecs[6] = '{16'h0000, 16'h0000, 3'd0};  // ch3 reads as zero
        vecs[7] = '{16'hC7FF, 16'h0ABC, 3'd0};  // junk outside [13:11]
        vecs[8] = '{16'hE800, 16'h0ABC, 3'd5};
        vecs[9] = '{16'h0000, 16'h0456, 3'd0};

        rst   = 1'b1;
        ss_n  = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        lft   = 12'hABC;
        rght  = 12'h123;
        steer = 12'h456;
        batt  = 12'hC90;
        wait_clks(4);
        check("reset_miso", {15'd0, miso}, 16'h0000);
        check("reset_chnl", {13'd0, dut.chnl_q}, 16'h0000);
        rst = 1'b0;
        wait_clks(6);

        // ---------------- table-driven frames ----------------
        for (int v = 0; v < 10; v++) begin
            spi_frame(vecs[v].cmd, 16, 1'b0, 12'h000, resp);
            check($sformatf("vec%0d_resp", v), resp, vecs[v].exp_resp);
            check($sformatf("vec%0d_chnl", v), {13'd0, dut.chnl_q},
                  {13'd0, vecs[v].exp_chnl});
        end

        // ---------------- input captured only at frame end -----------
        batt = 12'h800;
        spi_frame(16'h3000, 16, 1'b0, 12'h000, resp);
        check("batt_sel_resp", resp, 16'h0ABC);
        spi_frame(16'h3000, 16, 1'b1, 12'h7FF, resp);
        check("batt_hold_resp", resp, 16'h0800);
        spi_frame(16'h0000, 16, 1'b0, 12'h000, resp);
        check("batt_new_resp", resp, 16'h07FF);

        // ---------------- aborted frame ----------------
        spi_frame(16'h2800, 8, 1'b0, 12'h000, resp);
        check("abort_chnl", {13'd0, dut.chnl_q}, 16'h0000);
        spi_frame(16'h0000, 16, 1'b0, 12'h000, resp);
        check("abort_next_resp", resp, 16'h0ABC);

        // ---------------- reset mid-frame ----------------
        lft = 12'hFFF;
        spi_frame(16'h0000, 16, 1'b0, 12'h000, resp);
        check("prep_resp", resp, 16'h0ABC);
        ss_n = 1'b0;
        mosi = 1'b0;
        wait_clks(PH);
        for (int i = 0; i < 6; i++) begin
            wait_clks(PH);
            sclk = 1'b1;
            wait_clks(PH);
            sclk = 1'b0;
        end
        wait_clks(PH);
        // Six falls past the first rise leave data bit 9 (=1) on MISO.
        check("pre_reset_miso", {15'd0, miso}, 16'h0001);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_miso", {15'd0, miso}, 16'h0000);
        wait_clks(2);
        check("mid_reset_chnl", {13'd0, dut.chnl_q}, 16'h0000);
        rst = 1'b0;
        // Bus frame still in progress: SCLK activity must not start a frame.
        for (int i = 0; i < 2; i++) begin
            wait_clks(PH);
            sclk = 1'b1;
            wait_clks(PH);
            sclk = 1'b0;
        end
        wait_clks(PH);
        check("post_reset_miso", {15'd0, miso}, 16'h0000);
        ss_n = 1'b1;
        wait_clks(PH);
        spi_frame(16'h0000, 16, 1'b0, 12'h000, resp);
        check("post_reset_resp", resp, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
